// File: rtl/fp16_pkg.sv
// Shared fp16 format constants, FSM state type and the unpacked-operand
// record used by the sequential mantissa multiplier front end.
package fp16_pkg;

  localparam int FP16_BIAS   = 15;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int MANT_W      = 11;
  localparam int PROD_W      = 22;
  localparam int EXP_SUM_W   = 7;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] eff_exp;
    logic [MANT_W-1:0]     mant;
    logic                  zero;
    logic                  inf;
    logic                  nan;
  } fp16_unpacked_t;

endpackage

// File: rtl/fp16_mant_mul_seq_if.sv
// Operand/result handshake bundle between an upstream issuer (master)
// and the sequential mantissa multiplier (slave).
interface fp16_mant_mul_seq_if;
  import fp16_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          a;
  logic [15:0]          b;
  logic                 out_valid;
  logic                 out_ready;
  logic [PROD_W-1:0]    prod;
  logic                 sign;
  logic [EXP_SUM_W-1:0] exp_sum;
  logic                 is_zero;
  logic                 is_inf;
  logic                 is_nan;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, sign, exp_sum, is_zero, is_inf, is_nan
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, sign, exp_sum, is_zero, is_inf, is_nan
  );

endinterface

// File: rtl/fp16_unpack.sv
// Splits one fp16 word into sign, effective exponent, hidden-bit mantissa
// and special-value class flags.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]    word,
  output fp16_unpacked_t unp
);

  logic [FP16_EXP_W-1:0]  e;
  logic [FP16_FRAC_W-1:0] f;
  logic                   exp_zero;
  logic                   exp_max;
  logic                   frac_zero;

  assign e         = word[14:10];
  assign f         = word[9:0];
  assign exp_zero  = (e == '0);
  assign exp_max   = (e == '1);
  assign frac_zero = (f == '0);

  always_comb begin
    unp.sign = word[15];
    // Subnormals share the exponent of the smallest normal, without the hidden bit
    unp.eff_exp = exp_zero ? FP16_EXP_W'(1) : e;
    unp.mant    = {~exp_zero, f};
    unp.zero    = exp_zero & frac_zero;
    unp.inf     = exp_max & frac_zero;
    unp.nan     = exp_max & ~frac_zero;
  end

endmodule

// File: rtl/fp16_mant_mul_seq.sv
// Sequential fp16 multiply front end: sign, biased exponent sum, class flags
// and an exact 22-bit mantissa product built by an 11-step shift-add loop.
module fp16_mant_mul_seq
  import fp16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fp16_mant_mul_seq_if.slave  bus
);

  fp16_unpacked_t ua;
  fp16_unpacked_t ub;

  fp16_unpack u_unpack_a (.word(bus.a), .unp(ua));
  fp16_unpack u_unpack_b (.word(bus.b), .unp(ub));

  logic                 nan_next;
  logic                 inf_next;
  logic                 zero_next;
  logic [EXP_SUM_W-1:0] exp_sum_next;

  always_comb begin
    nan_next  = ua.nan | ub.nan | (ua.inf & ub.zero) | (ua.zero & ub.inf);
    inf_next  = (ua.inf | ub.inf) & ~nan_next;
    zero_next = (ua.zero | ub.zero) & ~nan_next & ~inf_next;
    exp_sum_next = EXP_SUM_W'(ua.eff_exp) + EXP_SUM_W'(ub.eff_exp)
                 - EXP_SUM_W'(FP16_BIAS);
  end

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [MANT_W-1:0]    mcand_reg;
  logic [MANT_W-1:0]    mplier_reg;
  logic [PROD_W-1:0]    acc_reg;
  logic                 sign_reg;
  logic [EXP_SUM_W-1:0] exp_sum_reg;
  logic                 zero_reg;
  logic                 inf_reg;
  logic                 nan_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;

  logic [PROD_W-1:0]    addend;

  // Partial product for the current multiplier bit; max sum 0x3FF001 fits 22 bits
  assign addend = mplier_reg[cnt_reg] ? (PROD_W'(mcand_reg) << cnt_reg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      sign_reg      <= 1'b0;
      exp_sum_reg   <= '0;
      zero_reg      <= 1'b0;
      inf_reg       <= 1'b0;
      nan_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_reg    <= ua.mant;
            mplier_reg   <= ub.mant;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sign_reg     <= ua.sign ^ ub.sign;
            exp_sum_reg  <= exp_sum_next;
            zero_reg     <= zero_next;
            inf_reg      <= inf_next;
            nan_reg      <= nan_next;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL;
          end
        end
        MUL: begin
          acc_reg <= acc_reg + addend;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(MANT_W - 1)) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.prod      = acc_reg;
  assign bus.sign      = sign_reg;
  assign bus.exp_sum   = exp_sum_reg;
  assign bus.is_zero   = zero_reg;
  assign bus.is_inf    = inf_reg;
  assign bus.is_nan    = nan_reg;

endmodule

// File: tb/tb_fp16_mant_mul_seq.sv
// Directed bench for fp16_mant_mul_seq: expected results are queued at the
// accept edge and compared when the result handshake completes.
module tb_fp16_mant_mul_seq;

  typedef struct {
    logic [21:0] prod;
    logic [6:0]  exp_sum;
    logic        sign;
    logic        zero;
    logic        inf;
    logic        nan;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  fp16_mant_mul_seq_if intf ();

  fp16_mant_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int ea, eb, ma, mb;
    logic za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea != 0) ? 1024 + int'(a[9:0]) : int'(a[9:0]);
    mb = (eb != 0) ? 1024 + int'(b[9:0]) : int'(b[9:0]);
    za = (ea == 0) && (a[9:0] == 0);
    zb = (eb == 0) && (b[9:0] == 0);
    ia = (ea == 31) && (a[9:0] == 0);
    ib = (eb == 31) && (b[9:0] == 0);
    na = (ea == 31) && (a[9:0] != 0);
    nb = (eb == 31) && (b[9:0] != 0);
    r.prod    = 22'(ma * mb);
    r.exp_sum = 7'(((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 15);
    r.sign    = a[15] ^ b[15];
    r.nan     = na | nb | (ia & zb) | (za & ib);
    r.inf     = (ia | ib) & ~r.nan;
    r.zero    = (za | zb) & ~r.nan & ~r.inf;
    return r;
  endfunction

  // Present operands, wait for acceptance and enqueue the expected result.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    intf.a = a;
    intf.b = b;
    intf.in_valid = 1'b1;
    n = 0;
    while (!intf.in_ready && n < 30) begin
      step();
      n++;
    end
    if (!intf.in_ready) begin
      failures++;
      $display("FAIL accept_timeout in_ready=0 required=1");
    end
    step();
    intf.in_valid = 1'b0;
    sb.push_back(model(a, b));
  endtask

  // Wait for out_valid and check the cycle count from the accept edge.
  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!intf.out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd11);
  endtask

  // Compare visible result against the scoreboard head and complete handshake.
  task automatic receive(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty observed=0 required=1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_out_valid"}, 32'(intf.out_valid), 32'd1);
    check({tag, "_prod"},      32'(intf.prod),      32'(e.prod));
    check({tag, "_exp_sum"},   32'(intf.exp_sum),   32'(e.exp_sum));
    check({tag, "_sign"},      32'(intf.sign),      32'(e.sign));
    check({tag, "_is_zero"},   32'(intf.is_zero),   32'(e.zero));
    check({tag, "_is_inf"},    32'(intf.is_inf),    32'(e.inf));
    check({tag, "_is_nan"},    32'(intf.is_nan),    32'(e.nan));
    check({tag, "_in_ready_done"}, 32'(intf.in_ready), 32'd0);
    intf.out_ready = 1'b1;
    step();
    intf.out_ready = 1'b0;
    check({tag, "_in_ready_after"},  32'(intf.in_ready),  32'd1);
    check({tag, "_out_valid_after"}, 32'(intf.out_valid), 32'd0);
    $display("op %s prod=0x%06h exp_sum=%0d sign=%0b z/i/n=%0b%0b%0b",
             tag, intf.prod, $signed(intf.exp_sum), intf.sign,
             intf.is_zero, intf.is_inf, intf.is_nan);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    send(a, b);
    wait_result(tag);
    receive(tag);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  32'(intf.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(intf.out_valid), 32'd0);
    check({tag, "_prod"},      32'(intf.prod),      32'd0);
    check({tag, "_exp_sum"},   32'(intf.exp_sum),   32'd0);
    check({tag, "_sign"},      32'(intf.sign),      32'd0);
    check({tag, "_flags"},
          32'({intf.is_zero, intf.is_inf, intf.is_nan}), 32'd0);
  endtask

  initial begin
    logic [21:0] held_prod;
    logic [6:0]  held_exp;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    intf.in_valid = 1'b0;
    intf.out_ready = 1'b0;
    intf.a = '0;
    intf.b = '0;
    step();
    step();
    rst = 1'b0;
    check_idle_zero("reset");

    // Literal spot checks for the first two cases
    send(16'h3C00, 16'h3C00);
    wait_result("one_x_one");
    check("one_x_one_prod_lit", 32'(intf.prod), 32'h100000);
    check("one_x_one_exp_lit",  32'(intf.exp_sum), 32'd15);
    receive("one_x_one");

    run_op("p15_x_m15", 16'h3E00, 16'hBE00);
    run_op("max_mant",  16'h7BFF, 16'h7BFF);
    run_op("subnormal", 16'h0001, 16'h3C00);
    run_op("inf_x_zero", 16'h7C00, 16'h0000);
    run_op("inf_x_one",  16'h7C00, 16'h3C00);
    run_op("negz_x_two", 16'h8000, 16'h4000);
    run_op("nan_x_one",  16'h7E01, 16'h3C00);
    run_op("sub_x_sub",  16'h83FF, 16'h0200);

    // Backpressure: result held for 5 cycles, operand churn ignored
    send(16'h4248, 16'hC555);
    wait_result("bp");
    held_prod = intf.prod;
    held_exp  = intf.exp_sum;
    intf.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      intf.a = 16'($urandom);
      intf.b = 16'($urandom);
      step();
      check("bp_out_valid_hold", 32'(intf.out_valid), 32'd1);
      check("bp_in_ready_low",   32'(intf.in_ready),  32'd0);
      check("bp_prod_hold",      32'(intf.prod),      32'(held_prod));
      check("bp_exp_hold",       32'(intf.exp_sum),   32'(held_exp));
    end
    intf.in_valid = 1'b0;
    receive("bp");
    run_op("after_bp", 16'h3C01, 16'h3BFF);

    // Reset in the middle of MUL drops the operation entirely
    send(16'h7BFF, 16'hFBFF);
    for (int i = 0; i < 5; i++) step();
    check("mid_rst_busy", 32'(intf.in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    check_idle_zero("mid_rst");
    run_op("post_rst", 16'h3C00, 16'h3C00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp16_mant_mul_seq.md
# fp16_mant_mul_seq

Sequential front end of the fp16 multiplier datapath. Accepts two fp16 operands, unpacks them, and forms the sign, the biased exponent sum and the exact 22-bit mantissa product with an iterative shift-add multiplier. Its result feeds the multiplier's normalise/round stage, which consumes the 22-bit product and returns a 10-bit rounded mantissa plus a normalisation shift. A valid/ready handshake sits on both sides.

## Interface
- No parameters. Widths are fixed by the fp16 format and taken from `fp16_pkg`.
- `clk` input 1: single clock. All logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands `a`/`b` present.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input 16: fp16 operand A.
- `b` input 16: fp16 operand B.
- `out_valid` output 1: result fields valid.
- `out_ready` input 1: downstream accepts result.
- `prod` output 22: exact product of 11-bit mantissas, hidden bit included. Bit 21 or bit 20 is the MSB for normal operands.
- `sign` output 1: `a[15] ^ b[15]`.
- `exp_sum` output 7: signed two's-complement value of eff(ea) + eff(eb) − 15.
- `is_zero` output 1: result is zero.
- `is_inf` output 1: result is infinity.
- `is_nan` output 1: result is NaN.

## Operation
- **Unpack (per operand):**
  - e = bits[14:10], f = bits[9:0].
  - Hidden bit h = (e != 0).
  - Mantissa m = {h, f} (11 bits).
  - Effective exponent eff(e) = (e == 0) ? 1 : e.
  - Class flags: zero = (e == 0 && f == 0); inf = (e == 31 && f == 0); nan = (e == 31 && f != 0).
- **States:** IDLE, MUL, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`:
    - Latch the multiplicand mA and the multiplier mB.
    - Clear the 22-bit accumulator.
    - Set `cnt` = 0.
    - Compute and register `sign`, `exp_sum` and the flags.
    - Go to MUL.
- **MUL:**
  - Each cycle: if mB[cnt] is set, acc += mA << cnt. Unsigned arithmetic; acc is 22 bits and cannot overflow, since max is 0x7FF² = 0x3FF001.
  - `cnt` increments each cycle.
  - When `cnt` == 10 at the edge: go to DONE.
- **DONE:**
  - `out_valid` = 1; `prod` = acc.
  - On `out_ready`: go to IDLE.
- **Flag rules:**
  - `is_nan` = nanA | nanB | (infA & zeroB) | (zeroA & infB).
  - `is_inf` = (infA | infB) & !is_nan.
  - `is_zero` = (zeroA | zeroB) & !is_nan & !is_inf.
  - `prod` and `exp_sum` are still computed for special operands. Downstream ignores them when any flag is set.
- **Exponent:** `exp_sum` range is −13..+45. Underflow and overflow are not handled here; they are resolved downstream.

## Timing
- **Reset:**
  - State = IDLE; `in_ready` = 1; `out_valid` = 0.
  - `prod`, `exp_sum`, `sign`, `is_zero`, `is_inf`, `is_nan` = 0; `cnt` = 0.
  - Reset asserted in any state returns to IDLE on that edge and drops the in-flight operation with no output.
- **Latency:**
  - Accept edge E0, then 11 MUL edges E1..E11.
  - `out_valid` is high in the cycle after E11: 11 cycles from accept to result.
- **Backpressure:**
  - While `out_valid` = 1 and `out_ready` = 0, all outputs hold stable.
  - `in_ready` stays 0 during this time.
- **Throughput:** the DONE → IDLE transition takes one edge, so `in_ready` is low in DONE. Minimum issue interval is 13 cycles.
- **Operand stability:** `a`/`b` are sampled only at the accept edge. Changes during MUL or DONE have no effect.
- `in_valid` asserted in a non-IDLE state is ignored. The upstream must hold it until `in_ready`.

## Structure
- **`fp16_pkg`:**
  - `FP16_BIAS` = 15, `FP16_EXP_W` = 5, `FP16_FRAC_W` = 10, `MANT_W` = 11, `PROD_W` = 22, `EXP_SUM_W` = 7.
  - State enum {IDLE, MUL, DONE}.
  - Typedef for the unpacked operand struct: sign, effective exponent, mantissa, and the zero/inf/nan flags.
- **Sub-module `fp16_unpack`:** combinational. Takes one fp16 word and returns the unpacked struct. Instantiated twice.
- **Top:** FSM, counter, accumulator, output registers.

## Test plan
- 1.0 × 1.0: a=0x3C00, b=0x3C00 → after 11 cycles `prod`=0x100000, `exp_sum`=15, `sign`=0, all flags 0.
- 1.5 × −1.5: a=0x3E00, b=0xBE00 → `prod`=0x240000, `exp_sum`=15, `sign`=1.
- Max mantissa and subnormal:
  - a=b=0x7BFF → `prod`=0x3FF001, `exp_sum`=45.
  - a=0x0001, b=0x3C00 → `prod`=0x000400, `exp_sum`=1.
- Specials:
  - 0x7C00 × 0x0000 → `is_nan`=1.
  - 0x7C00 × 0x3C00 → `is_inf`=1.
  - 0x8000 × 0x4000 → `is_zero`=1, `sign`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs stable, `in_ready`=0. Then `out_ready`=1 → IDLE next edge and a new accept succeeds.
- Reset mid-operation: assert `rst` at MUL cycle 5 → next cycle `in_ready`=1, `out_valid`=0, outputs 0. A following 1.0 × 1.0 produces the correct result with no stale data.
